pr_stage_skid: RTL
==================

Name: pr_stage_skid

Overview:
- Parametrised pipeline stage register; the general replacement for the fixed-width per-stage registers (IF/ID, ID/EX, ...).
- Carries an arbitrary-width payload with a valid/ready handshake.
- A one-entry skid buffer registers in_ready, so downstream stalls never propagate combinationally upstream.
- Flush and reset load a bubble value (default: NOP instruction with PC 0x3000).

Parameters:
- DATA_W, 64, payload width in bits (default packs {Instr[31:0], PC[31:0]}).
- BUBBLE_VAL, 64'h0000_0000_0000_3000, value driven on out_data whenever out_valid=0. Width DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low (asserted at 0).
- flush  input  1  synchronous clear of all held entries; active-high.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage accepts data; registered output.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload; equals BUBBLE_VAL when out_valid=0.
- stall_cnt  output  32  present only with PR_STAGE_PERF_EN (see Optional Feature).

Behaviour:
- Storage: main register (drives out_data/out_valid) plus skid register (skid_data, skid_valid).
- in_ready = ~skid_valid, taken directly from a flop; no combinational path from out_ready.
- Handshakes:
  - accept = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - Both evaluated at the rising edge.
- State machine, encoded by {skid_valid, out_valid}:
  - EMPTY (00):
    - accept -> ONE; main <= in_data.
    - otherwise stay EMPTY.
  - ONE (01):
    - accept & emit -> ONE; main <= in_data.
    - accept & ~emit -> FULL; skid <= in_data.
    - ~accept & emit -> EMPTY; main <= BUBBLE_VAL.
    - neither -> hold.
  - FULL (11):
    - in_ready=0, so no accept is possible.
    - emit -> ONE; main <= skid; skid_data <= BUBBLE_VAL.
    - ~emit -> hold.
  - State 10 is unreachable. If it is ever reached, it is treated as EMPTY on the next edge and both valids are cleared.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY or draining. Throughput is 1 entry/cycle when out_ready is held high.
- Ordering: strictly FIFO; the skid entry is never emitted before the main entry.
- Flush:
  - Next edge: out_valid=0, skid_valid=0, out_data=BUBBLE_VAL, skid_data=BUBBLE_VAL, in_ready=1.
  - A simultaneous accept is discarded; a simultaneous emit still counts as consumed downstream.
- Priority: rst=0 over flush over normal operation.
- Reset (rst=0 at edge): same register values as flush. Reset mid-transfer loses both entries; no partial state is kept.
- out_ready may be asserted while out_valid=0; it has no effect.
- in_data is ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: PR_STAGE_PERF_EN.
- Defined:
  - Port stall_cnt[31:0] exists.
  - Increments each cycle where out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared to 0 by rst=0; NOT cleared by flush.
- Undefined: no stall_cnt port, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> out_valid=0, out_data=64'h0000_0000_0000_3000, in_ready=1; stall_cnt=0 if enabled.
- Streaming: out_ready=1, drive in_data = 1,2,3,4 on consecutive cycles with in_valid=1 -> out_data shows 1,2,3,4 one cycle later; in_ready stays 1 throughout.
- Skid fill: load A=0xAA, drop out_ready, present B=0xBB -> FULL, in_ready=0 on the next cycle; raise out_ready -> A emitted, then B; in_ready returns to 1 one cycle after A leaves.
- Drain to bubble: stage in ONE holding 0x55, no new input, out_ready=1 -> next cycle out_valid=0 and out_data=BUBBLE_VAL.
- Flush in FULL with simultaneous in_valid=1 carrying 0xCC -> next cycle out_valid=0, in_ready=1, 0xCC never appears on out_data.
- Perf (PR_STAGE_PERF_EN): hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt still 5; rst=0 -> stall_cnt=0.

Source files
------------

// File: rtl/pr_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer and a valid/ready handshake.
// Optional stall counter port stall_cnt is built when PR_STAGE_PERF_EN is defined.
module pr_stage_skid #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = 64'h0000_0000_0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PR_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // State code is {skid_valid, out_valid}; BAD is the unreachable 10 pattern
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    BAD   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   main_next_s;
  logic [DATA_W-1:0]   skid_r;
  logic [DATA_W-1:0]   skid_next_s;
  logic                accept_s;
  logic                emit_s;

  // in_ready and out_valid come straight from state flops, so out_ready never reaches in_ready
  assign in_ready  = ~state_r[1];
  assign out_valid = state_r[0];
  assign out_data  = main_r;

  assign accept_s = in_valid & in_ready;
  assign emit_s   = out_valid & out_ready;

  // Next-state and payload-move decode
  always_comb begin
    state_next_s = state_r;
    main_next_s  = main_r;
    skid_next_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = ONE;
          main_next_s  = in_data;
        end else begin
          state_next_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && emit_s) begin
          main_next_s = in_data;
        end else if (accept_s) begin
          state_next_s = FULL;
          skid_next_s  = in_data;
        end else if (emit_s) begin
          state_next_s = EMPTY;
          main_next_s  = BUBBLE_VAL;
        end else begin
          state_next_s = ONE;
        end
      end
      FULL: begin
        if (emit_s) begin
          state_next_s = ONE;
          main_next_s  = skid_r;
          skid_next_s  = BUBBLE_VAL;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        // Recover from the illegal code by dropping both entries
        state_next_s = EMPTY;
        main_next_s  = BUBBLE_VAL;
        skid_next_s  = BUBBLE_VAL;
      end
    endcase
  end

  // State and payload registers; reset and flush both load the bubble and discard any accept
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_r <= EMPTY;
      main_r  <= BUBBLE_VAL;
      skid_r  <= BUBBLE_VAL;
    end else begin
      state_r <= state_next_s;
      main_r  <= main_next_s;
      skid_r  <= skid_next_s;
    end
  end

`ifdef PR_STAGE_PERF_EN
  logic [31:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating count of cycles where valid output is held back; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule
